sht10_value_convert: RTL and testbench

//  Converts one raw SHT10 reading into a display-ready 4-digit packed BCD value, fixed-point, no floats.

---
 rtl/sht10_value_convert_if.sv | 24 ++
 rtl/sht10_value_convert.sv | 139 +++++++++++++
 tb/tb_sht10_value_convert.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/sht10_value_convert_if.sv
// Handshake/result bundle between the SHT10 serial front end, the converter and the BCD consumer.
interface sht10_value_convert_if;
   logic        in_valid;
   logic        in_sel;
   logic [15:0] in_data;
   logic        in_error;
   logic        in_ready;
   logic        out_valid;
   logic        out_sel;
   logic [15:0] out_bcd;
   logic        out_neg;
   logic        out_ovr;
   logic        out_err;
   logic        overrun;

   modport master (
      output in_valid, in_sel, in_data, in_error,
      input  in_ready, out_valid, out_sel, out_bcd, out_neg, out_ovr, out_err, overrun
   );
   modport slave (
      input  in_valid, in_sel, in_data, in_error,
      output in_ready, out_valid, out_sel, out_bcd, out_neg, out_ovr, out_err, overrun
   );
endinterface

// File: rtl/sht10_value_convert.sv
// Raw SHT10 word -> 4-digit packed BCD (0.01 degC or linearised 0.01 %RH) using one shared
// multiplier and a 14-cycle sequential double-dabble.
module sht10_value_convert #(
   parameter logic [15:0] T_OFFSET = 16'd3970,
   parameter logic [31:0] RH_C1    = 32'd3433960571,
   parameter logic [25:0] RH_C2    = 26'd61572383,
   parameter logic [11:0] RH_C3    = 12'd2677
) (
   input  logic               clock,
   input  logic               reset,
   sht10_value_convert_if.slave bus
);
   typedef enum logic [2:0] {IDLE, MUL1, MUL2, MUL3, SUM, CLAMP, BCD, DONE} state_t;

   state_t state, nxt;

   logic               sel_q, err_q, neg_q, ovr_q;
   logic [13:0]        so_q, bin_q;
   logic [23:0]        sq_q;
   logic signed [39:0] acc_q;
   logic signed [15:0] v_q;
   logic [15:0]        bcd_q;
   logic [3:0]         cnt_q;

   logic [25:0]        mul_a;
   logic [23:0]        mul_b;
   logic [39:0]        prod;
   logic signed [39:0] rh_sum;
   logic [15:0]        mag;
   logic               c_neg, c_ovr;
   logic [15:0]        bcd_adj;

   assign bus.in_ready = (state == IDLE);

   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else       state <= nxt;
   end

   always_comb begin
      nxt = state;
      case (state)
         IDLE:    if (bus.in_valid) nxt = bus.in_error ? DONE : (bus.in_sel ? MUL1 : SUM);
         MUL1:    nxt = MUL2;
         MUL2:    nxt = MUL3;
         MUL3:    nxt = SUM;
         SUM:     nxt = CLAMP;
         CLAMP:   nxt = BCD;
         BCD:     if (cnt_q == 4'd13) nxt = DONE;
         DONE:    nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   // Single multiplier, operands steered by state; 40-bit context keeps every product exact.
   always_comb begin
      mul_a = '0;
      mul_b = '0;
      case (state)
         MUL1: begin mul_a = {12'd0, so_q}; mul_b = {10'd0, so_q}; end
         MUL2: begin mul_a = {14'd0, RH_C3}; mul_b = sq_q; end
         MUL3: begin mul_a = RH_C2; mul_b = {10'd0, so_q}; end
         default: ;
      endcase
      prod = mul_a * mul_b;
   end

   assign rh_sum = acc_q - $signed({8'd0, RH_C1}) + 40'sd8388608;

   always_comb begin
      mag   = v_q;
      c_neg = 1'b0;
      c_ovr = 1'b0;
      if (v_q < 0) begin
         if (!sel_q) begin c_neg = 1'b1; mag = -v_q; end
         else        begin c_ovr = 1'b1; mag = '0;   end
      end
      if (mag > 16'd9999) begin
         mag   = 16'd9999;
         c_ovr = 1'b1;
      end
   end

   always_comb begin
      bcd_adj = bcd_q;
      for (int d = 0; d < 4; d++)
         if (bcd_q[4*d +: 4] >= 4'd5) bcd_adj[4*d +: 4] = bcd_q[4*d +: 4] + 4'd3;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         bus.out_valid <= 1'b0;
         bus.out_sel   <= 1'b0;
         bus.out_bcd   <= 16'h0000;
         bus.out_neg   <= 1'b0;
         bus.out_ovr   <= 1'b0;
         bus.out_err   <= 1'b0;
         bus.overrun   <= 1'b0;
         sel_q <= 1'b0; err_q <= 1'b0; neg_q <= 1'b0; ovr_q <= 1'b0;
         so_q  <= '0;   bin_q <= '0;   sq_q  <= '0;   acc_q <= '0;
         v_q   <= '0;   bcd_q <= '0;   cnt_q <= '0;
      end else begin
         bus.out_valid <= 1'b0;
         if (bus.in_valid && state != IDLE) bus.overrun <= 1'b1;
         case (state)
            IDLE: if (bus.in_valid) begin
               sel_q <= bus.in_sel;
               err_q <= bus.in_error;
               so_q  <= bus.in_sel ? {2'b00, bus.in_data[11:0]} : bus.in_data[13:0];
            end
            MUL1: sq_q  <= prod[23:0];
            MUL2: acc_q <= -$signed(prod);
            MUL3: acc_q <= acc_q + $signed(prod);
            SUM:  v_q   <= sel_q ? rh_sum[39:24] : $signed({2'b00, so_q}) - $signed(T_OFFSET);
            CLAMP: begin
               neg_q <= c_neg;
               ovr_q <= c_ovr;
               bin_q <= mag[13:0];
               bcd_q <= '0;
               cnt_q <= '0;
            end
            BCD: begin
               bcd_q <= {bcd_adj[14:0], bin_q[13]};
               bin_q <= {bin_q[12:0], 1'b0};
               cnt_q <= cnt_q + 4'd1;
            end
            DONE: begin
               bus.out_valid <= 1'b1;
               bus.out_sel   <= sel_q;
               bus.out_err   <= err_q;
               bus.out_bcd   <= err_q ? 16'hFFFF : bcd_q;
               bus.out_neg   <= err_q ? 1'b0 : neg_q;
               bus.out_ovr   <= err_q ? 1'b0 : ovr_q;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_sht10_value_convert.sv
// Scoreboard bench: the driver queues hand-computed results, a negedge monitor pops and compares.
module tb_sht10_value_convert;
   logic clock = 1'b0;
   logic reset = 1'b1;
   sht10_value_convert_if bus();

   sht10_value_convert dut (.clock(clock), .reset(reset), .bus(bus));

   always #5 clock = ~clock;

   typedef struct {
      logic        sel;
      logic [15:0] bcd;
      logic        neg;
      logic        ovr;
      logic        err;
      int          edge_no;
   } exp_t;

   exp_t sbq[$];
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;

   always @(posedge clock) cyc = cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   always @(negedge clock) begin
      if (!reset && bus.out_valid) begin
         if (sbq.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_out_valid: got pulse at edge %0d want none", cyc);
         end else begin
            exp_t e;
            e = sbq.pop_front();
            check("out_edge", cyc,         e.edge_no);
            check("out_sel",  bus.out_sel, e.sel);
            check("out_bcd",  bus.out_bcd, e.bcd);
            check("out_neg",  bus.out_neg, e.neg);
            check("out_ovr",  bus.out_ovr, e.ovr);
            check("out_err",  bus.out_err, e.err);
         end
      end
   end

   // Drives one word for one cycle; exp is pushed only when a result is expected.
   task automatic send(input logic sel, input logic [15:0] data, input logic err,
                       input logic push, input logic [15:0] bcd, input logic neg,
                       input logic ovr, input int lat);
      exp_t e;
      @(negedge clock);
      bus.in_valid = 1'b1; bus.in_sel = sel; bus.in_data = data; bus.in_error = err;
      if (push) begin
         e.sel = sel; e.bcd = bcd; e.neg = neg; e.ovr = ovr; e.err = err;
         e.edge_no = cyc + 1 + lat;
         sbq.push_back(e);
      end
      @(negedge clock);
      bus.in_valid = 1'b0; bus.in_error = 1'b0;
   endtask

   task automatic drain;
      int n;
      n = 0;
      while (sbq.size() != 0 && n < 60) begin
         @(negedge clock);
         n++;
      end
      if (sbq.size() != 0) begin
         total++; bad++;
         $display("FAIL drain_timeout: got %0d pending want 0", sbq.size());
         sbq.delete();
      end
      repeat (3) @(negedge clock);
   endtask

   initial begin
      bus.in_valid = 1'b0; bus.in_sel = 1'b0; bus.in_data = '0; bus.in_error = 1'b0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      check("rst_out_valid", bus.out_valid, 1'b0);
      check("rst_out_bcd",   bus.out_bcd,   16'h0000);
      check("rst_out_flags", {bus.out_sel, bus.out_neg, bus.out_ovr, bus.out_err}, 4'b0000);
      check("rst_overrun",   bus.overrun,   1'b0);
      check("rst_in_ready",  bus.in_ready,  1'b1);

      // temperature: normal, negative, clamped high
      send(1'b0, 16'h18AB, 1'b0, 1'b1, 16'h2345, 1'b0, 1'b0, 17); drain();
      send(1'b0, 16'd3000, 1'b0, 1'b1, 16'h0970, 1'b1, 1'b0, 17); drain();
      send(1'b0, 16'd16000, 1'b0, 1'b1, 16'h9999, 1'b0, 1'b1, 17); drain();
      send(1'b0, 16'd3970, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 17); drain();
      // upper bits of in_data are ignored
      send(1'b0, 16'hD8AB, 1'b0, 1'b1, 16'h2345, 1'b0, 1'b0, 17); drain();

      // RH: normal, clamped low, clamped high
      send(1'b1, 16'd1500, 1'b0, 1'b1, 16'h4941, 1'b0, 1'b0, 20); drain();
      send(1'b1, 16'd0,    1'b0, 1'b1, 16'h0000, 1'b0, 1'b1, 20); drain();
      send(1'b1, 16'd4095, 1'b0, 1'b1, 16'h9999, 1'b0, 1'b1, 20); drain();
      send(1'b1, 16'hF5DC, 1'b0, 1'b1, 16'h4941, 1'b0, 1'b0, 20); drain();

      // error-qualified words
      send(1'b0, 16'h18AB, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1); drain();
      send(1'b1, 16'd1500, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1); drain();
      check("overrun_clear", bus.overrun, 1'b0);

      // overrun: second word 5 cycles into an RH conversion is dropped
      send(1'b1, 16'd1500, 1'b0, 1'b1, 16'h4941, 1'b0, 1'b0, 20);
      repeat (2) @(negedge clock);
      send(1'b0, 16'd6315, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 0);
      check("overrun_set", bus.overrun, 1'b1);
      drain();
      repeat (25) @(negedge clock);
      check("overrun_sticky", bus.overrun, 1'b1);

      // reset in the middle of BCD aborts the conversion
      send(1'b0, 16'h18AB, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 0);
      repeat (8) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      check("mid_rst_in_ready", bus.in_ready,  1'b1);
      check("mid_rst_valid",    bus.out_valid, 1'b0);
      check("mid_rst_overrun",  bus.overrun,   1'b0);
      check("mid_rst_bcd",      bus.out_bcd,   16'h0000);
      repeat (20) @(negedge clock);
      send(1'b0, 16'd6315, 1'b0, 1'b1, 16'h2345, 1'b0, 1'b0, 17); drain();
      send(1'b1, 16'd1500, 1'b0, 1'b1, 16'h4941, 1'b0, 1'b0, 20); drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
